// File: rtl/div_arctan_interface_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_arctan_interface_if
//  Description : Bundles the divider-side inputs, the arctan-side output
//                handshake and the status/error signals of
//                div_arctan_interface.
//                slave  : used by div_arctan_interface itself
//                master : used by whatever drives the divider side and
//                         consumes the arctan side
//  Ports       : none (interface signals only)
//                div_start, start_chan, start_swap   divide issue + tag
//                div_ready, div_quotient, div_remainder   divider result
//                out_valid, out_ready, out_chan, out_x, out_y, out_sat
//                tag_full, err_clear, err_overflow, err_orphan
//  Revision    : 1.0  initial release
// ============================================================================
interface div_arctan_interface_if #(
   parameter int QW = 12,
   parameter int FW = 8,
   parameter int CW = 1
);
   logic          div_start;
   logic [CW-1:0] start_chan;
   logic          start_swap;
   logic          div_ready;
   logic [QW-1:0] div_quotient;
   logic [FW-1:0] div_remainder;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_chan;
   logic [FW+1:0] out_x;
   logic [FW+1:0] out_y;
   logic          out_sat;
   logic          tag_full;
   logic          err_clear;
   logic          err_overflow;
   logic          err_orphan;

   modport slave (
      input  div_start, start_chan, start_swap,
      input  div_ready, div_quotient, div_remainder,
      input  out_ready, err_clear,
      output out_valid, out_chan, out_x, out_y, out_sat,
      output tag_full, err_overflow, err_orphan
   );

   modport master (
      output div_start, start_chan, start_swap,
      output div_ready, div_quotient, div_remainder,
      output out_ready, err_clear,
      input  out_valid, out_chan, out_x, out_y, out_sat,
      input  tag_full, err_overflow, err_orphan
   );
endinterface
`default_nettype wire

// File: rtl/div_arctan_interface.sv
`default_nettype none
// ============================================================================
//  Module      : div_arctan_interface
//  Description : Glue between a shared divider and the arctan stage. Each
//                issued divide queues {channel, swap} in a tag FIFO; each
//                divider result pops one tag, is converted to an (x, y)
//                fixed-point pair with the unit axis forced to 1.0, and is
//                buffered in an output FIFO drained by valid/ready.
//                Overflow and orphan-result conditions are sticky flags.
//  Ports       : clk_i    system clock
//                reset_i  asynchronous active-high reset
//                bus      div_arctan_interface_if.slave (divider inputs,
//                         output handshake, status and error flags)
//  Revision    : 1.0  initial release
// ============================================================================
module div_arctan_interface #(
   parameter int QW        = 12,
   parameter int FW        = 8,
   parameter int NCHAN     = 2,
   parameter int CW        = 1,
   parameter int TAG_DEPTH = 4,
   parameter int OUT_DEPTH = 2
) (
   input  wire                         clk_i,
   input  wire                         reset_i,
   div_arctan_interface_if.slave       bus
);

   localparam int TAW = $clog2(TAG_DEPTH);
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam logic [TAW:0]  c_tag_depth = (TAW+1)'(TAG_DEPTH);
   localparam logic [OAW:0]  c_out_depth = (OAW+1)'(OUT_DEPTH);
   localparam logic [FW+1:0] c_one       = {2'b01, {FW{1'b0}}};

   if ((1 << CW) < NCHAN) begin : g_chan_width_check
      $error("CW too narrow for NCHAN");
   end

   // ---------------------------------------------------------------- tag FIFO
   logic [CW:0]  r_tag_mem_q [TAG_DEPTH];
   logic [TAW-1:0] r_tag_wr_q, r_tag_rd_q;
   logic [TAW:0] r_tag_cnt_q, r_tag_cnt_d;

   logic w_tag_empty, w_tag_full, w_tag_pop, w_tag_push;
   logic w_orphan_evt, w_start_drop_evt;

   assign w_tag_empty = (r_tag_cnt_q == '0);
   assign w_tag_full  = (r_tag_cnt_q == c_tag_depth);
   assign w_tag_pop   = bus.div_ready & ~w_tag_empty;
   // A pop in the same cycle frees the slot the start needs.
   assign w_tag_push  = bus.div_start & (~w_tag_full | w_tag_pop);
   assign w_orphan_evt     = bus.div_ready & w_tag_empty;
   assign w_start_drop_evt = bus.div_start & w_tag_full & ~w_tag_pop;

   // ---------------------------------------------------------- conversion
   logic [QW-2:0] w_mag;
   logic          w_sat;
   logic [FW+1:0] w_f, w_x, w_y;
   logic [CW-1:0] w_head_chan;
   logic          w_head_swap;

   always_comb begin
      w_mag       = bus.div_quotient[QW-2:0];
      w_sat       = (w_mag > (QW-1)'(1));
      w_head_chan = r_tag_mem_q[r_tag_rd_q][CW:1];
      w_head_swap = r_tag_mem_q[r_tag_rd_q][0];
      // |q| >= 2 clamps to signed 1.0; otherwise integer bit is mag[0].
      if (w_sat) begin
         w_f = {bus.div_quotient[QW-1], 1'b1, {FW{1'b0}}};
      end else begin
         w_f = {bus.div_quotient[QW-1], w_mag[0], bus.div_remainder};
      end
      if (w_head_swap) begin
         w_x = w_f;
         w_y = c_one;
      end else begin
         w_x = c_one;
         w_y = w_f;
      end
   end

   // ------------------------------------------------------------- out FIFO
   logic [CW-1:0] r_oc_mem_q [OUT_DEPTH];
   logic [FW+1:0] r_ox_mem_q [OUT_DEPTH];
   logic [FW+1:0] r_oy_mem_q [OUT_DEPTH];
   logic          r_os_mem_q [OUT_DEPTH];
   logic [OAW-1:0] r_out_wr_q, r_out_rd_q;
   logic [OAW:0]  r_out_cnt_q, r_out_cnt_d;

   logic w_out_valid, w_out_full, w_out_pop, w_out_push, w_result_drop_evt;

   assign w_out_valid = (r_out_cnt_q != '0);
   assign w_out_full  = (r_out_cnt_q == c_out_depth);
   assign w_out_pop   = w_out_valid & bus.out_ready;
   assign w_out_push  = w_tag_pop & (~w_out_full | w_out_pop);
   // The tag is still consumed so later results stay matched to their tags.
   assign w_result_drop_evt = w_tag_pop & w_out_full & ~w_out_pop;

   always_comb begin
      r_tag_cnt_d = r_tag_cnt_q;
      case ({w_tag_push, w_tag_pop})
         2'b10:   r_tag_cnt_d = r_tag_cnt_q + 1'b1;
         2'b01:   r_tag_cnt_d = r_tag_cnt_q - 1'b1;
         default: r_tag_cnt_d = r_tag_cnt_q;
      endcase
      r_out_cnt_d = r_out_cnt_q;
      case ({w_out_push, w_out_pop})
         2'b10:   r_out_cnt_d = r_out_cnt_q + 1'b1;
         2'b01:   r_out_cnt_d = r_out_cnt_q - 1'b1;
         default: r_out_cnt_d = r_out_cnt_q;
      endcase
   end

   // Storage arrays carry data only; occupancy is held by the counters.
   always_ff @(posedge clk_i) begin
      if (w_tag_push) begin
         r_tag_mem_q[r_tag_wr_q] <= {bus.start_chan, bus.start_swap};
      end
      if (w_out_push) begin
         r_oc_mem_q[r_out_wr_q] <= w_head_chan;
         r_ox_mem_q[r_out_wr_q] <= w_x;
         r_oy_mem_q[r_out_wr_q] <= w_y;
         r_os_mem_q[r_out_wr_q] <= w_sat;
      end
   end

   logic r_err_overflow_q, r_err_orphan_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_tag_wr_q       <= '0;
         r_tag_rd_q       <= '0;
         r_tag_cnt_q      <= '0;
         r_out_wr_q       <= '0;
         r_out_rd_q       <= '0;
         r_out_cnt_q      <= '0;
         r_err_overflow_q <= 1'b0;
         r_err_orphan_q   <= 1'b0;
      end else begin
         if (w_tag_push) r_tag_wr_q <= r_tag_wr_q + 1'b1;
         if (w_tag_pop)  r_tag_rd_q <= r_tag_rd_q + 1'b1;
         if (w_out_push) r_out_wr_q <= r_out_wr_q + 1'b1;
         if (w_out_pop)  r_out_rd_q <= r_out_rd_q + 1'b1;
         r_tag_cnt_q <= r_tag_cnt_d;
         r_out_cnt_q <= r_out_cnt_d;
         // A new event wins over a simultaneous clear.
         r_err_overflow_q <= (r_err_overflow_q & ~bus.err_clear)
                             | w_start_drop_evt | w_result_drop_evt;
         r_err_orphan_q   <= (r_err_orphan_q & ~bus.err_clear) | w_orphan_evt;
      end
   end

   // Head fields are forced to zero when empty so stale storage never shows.
   assign bus.out_valid    = w_out_valid;
   assign bus.out_chan     = w_out_valid ? r_oc_mem_q[r_out_rd_q] : '0;
   assign bus.out_x        = w_out_valid ? r_ox_mem_q[r_out_rd_q] : '0;
   assign bus.out_y        = w_out_valid ? r_oy_mem_q[r_out_rd_q] : '0;
   assign bus.out_sat      = w_out_valid & r_os_mem_q[r_out_rd_q];
   assign bus.tag_full     = w_tag_full;
   assign bus.err_overflow = r_err_overflow_q;
   assign bus.err_orphan   = r_err_orphan_q;

endmodule
`default_nettype wire

// File: doc/div_arctan_interface.md
Name: div_arctan_interface

Overview:
- Sits between the shared divider and the arctan stage; serves NCHAN channels (e.g. pan, tilt) through one divider.
- For each divide it queues the issuing channel and its swap flag, then converts the divider result into an (x, y) fixed-point pair for arctan, with the unit-valued operand forced to 1.0.
- Results are buffered in an output FIFO drained by a valid/ready handshake.
- Saturation, overflow and orphan-result conditions are flagged.

Parameters:
QW, 12, divider quotient width; bit QW-1 is sign, bits QW-2:0 are magnitude.
FW, 8, remainder/fraction width; output word width is FW+2.
NCHAN, 2, number of channels sharing the divider.
CW, 1, channel ID width; must satisfy 2^CW >= NCHAN.
TAG_DEPTH, 4, in-flight divide tag FIFO depth; power of two, >=2.
OUT_DEPTH, 2, output FIFO depth; power of two, >=2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
div_start  in  1  one-cycle pulse: a divide was issued this cycle
start_chan  in  CW  channel of the issued divide
start_swap  in  1  1: dividend was the larger axis (fraction goes to x); 0: fraction goes to y
div_ready  in  1  one-cycle pulse: divider result valid
div_quotient  in  QW  sign-magnitude quotient
div_remainder  in  FW  fractional bits
out_valid  out  1  output FIFO non-empty
out_ready  in  1  arctan stage accepts the head entry
out_chan  out  CW  channel of the head entry
out_x  out  FW+2  arctan x operand {sign, int, frac}
out_y  out  FW+2  arctan y operand
out_sat  out  1  head entry was saturated
tag_full  out  1  tag FIFO full
err_clear  in  1  synchronous clear of sticky error flags
err_overflow  out  1  sticky: start dropped (tag FIFO full) or result dropped (output FIFO full)
err_orphan  out  1  sticky: div_ready arrived with tag FIFO empty

Behaviour:
- Reset: both FIFOs empty. out_valid=0, out_chan=0, out_x=0, out_y=0, out_sat=0, tag_full=0, err_overflow=0, err_orphan=0.
- Tag FIFO: each entry is {start_chan, start_swap}.
  - Push on div_start when not full.
  - If div_start arrives while full, the tag is dropped and err_overflow is set.
  - Pop on div_ready when not empty.
  - Push and pop in the same cycle on a full FIFO both succeed.
  - div_ready with the FIFO empty sets err_orphan and discards the result, even if div_start is asserted that same cycle; that start is still pushed normally.
- Conversion (combinational from the tag FIFO head and the divider inputs):
  - mag = div_quotient[QW-2:0].
  - If mag==0 or mag==1: F = {div_quotient[QW-1], mag[0], div_remainder}, sat=0.
  - If mag>1: F = {div_quotient[QW-1], 1'b1, FW zeros} (signed 1.0), sat=1.
  - ONE = {2'b01, FW zeros}.
  - swap=1: x=F, y=ONE. swap=0: x=ONE, y=F.
- Output FIFO: each entry is {chan, x, y, sat}, written on the cycle div_ready is accepted.
  - Latency: div_ready in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty.
  - No combinational path from div_* to out_*.
  - If the output FIFO is full and no pop occurs that cycle, the result is dropped, err_overflow is set, and the tag is still popped so tag order stays aligned.
  - Pop and push in the same cycle on a full output FIFO both succeed.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_chan/out_x/out_y/out_sat stay stable while out_valid && !out_ready.
  - out_ready with out_valid=0 has no effect.
- Pointers wrap modulo depth; each FIFO tracks full/empty with a count of width log2(depth)+1.
- Error flags:
  - err_clear clears both flags.
  - If an error event and err_clear occur in the same cycle, the flag ends set.
- Reset asserted mid-operation discards all queued tags and results immediately; no partial output appears after release.
- start_chan >= NCHAN is carried through unchanged; this block does not range-check it.

Test Plan:
- Basic routing: div_start chan=1 swap=1; 5 cycles later div_ready q=0x000 r=0x80 -> next cycle out_valid=1, out_chan=1, out_x=0x080, out_y=0x100.
- Swap=0 with negative quotient: q=0x800, r=0x40 -> out_x=0x100, out_y=0x240; out_sat=0.
- Saturation: q=0x005, r=0x33, swap=1 -> out_x=0x100, out_y=0x100, out_sat=1. Repeat with q=0x805 -> out_x=0x300.
- Ordering and backpressure: 4 starts (chans 0,1,0,1, alternating swap) with out_ready=0 -> 2 results buffered, 3rd dropped with err_overflow=1. Raise out_ready -> entries emerge in issue order. Drive a 5th div_start while tag FIFO is full -> err_overflow stays 1 and tag_full=1.
- Orphan: div_ready with no pending tag -> err_orphan=1, out_valid stays 0. err_clear -> 0. Same-cycle div_start+div_ready on an empty tag FIFO -> orphan set and the tag is queued.
- Async reset asserted while 2 tags and 1 result are pending -> all outputs 0 immediately, without waiting for a clk edge. After release, a new div_ready -> err_orphan=1.
